// File: rtl/task_output_packetizer_pkg.sv
// Shared definitions for the task output packetizer.
//   task_output_state_e : packetizer FSM states
//   DEF_*               : default parameter values
//   words_to_bytes()    : byte size of a packet of whole words
package task_output_packetizer_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2
    } task_output_state_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_PKT_LEN = 256;
    localparam int DEF_SIZE_W  = 12;

    function automatic int unsigned words_to_bytes(input int unsigned words,
                                                   input int unsigned data_w);
        return words * (data_w / 8);
    endfunction

endpackage

// File: rtl/task_output_packetizer_fifo.sv
// Show-ahead synchronous FIFO: o_rdata is the head word whenever not empty.
// Ports:
//   i_clk, i_clr_n  : clock, synchronous active-low clear (pointers/count)
//   i_wr, i_wdata   : write strobe and data (ignored when full)
//   i_rd            : pop the head word (ignored when empty)
//   o_rdata         : head word
//   o_full, o_empty, o_count : occupancy status
module sync_fifo_showahead #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                       i_clk,
    input  logic                       i_clr_n,
    input  logic                       i_wr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic                       i_rd,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              do_wr, do_rd;

    always_comb begin
        do_wr  = i_wr && !o_full;
        do_rd  = i_rd && !o_empty;
        // DEPTH is a power of two, so the pointers wrap on their own
        wptr_d = wptr_q + AW'(do_wr);
        rptr_d = rptr_q + AW'(do_rd);
        cnt_d  = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // storage is not cleared; the pointers alone define what is valid
    always_ff @(posedge i_clk) begin
        if (do_wr && i_clr_n) mem_q[wptr_q] <= i_wdata;
    end

    assign o_rdata = mem_q[rptr_q];
    assign o_full  = (cnt_q == (AW+1)'(DEPTH));
    assign o_empty = (cnt_q == '0);
    assign o_count = cnt_q;

endmodule

// File: rtl/task_output_packetizer.sv
// Task output packetizer: buffers result words and sends them to the task
// manager as one packet when PKT_LEN words are collected or on i_flush.
// Ports:
//   i_clk, i_rst_n                 : clock, synchronous active-low reset
//   i_data, i_data_valid, i_flush  : result words from the task core
//   i_tmanager_ready               : manager accepts the current word
//   o_tanswer_ready, o_tdata,
//   o_tanswer_data_last            : packet beat, valid and last marker
//   o_packet_size_in_bytes         : byte size of the packet in flight, else 0
//   o_busy, o_full, o_drop         : status; o_drop pulses on discarded input
module task_output_packetizer
    import task_output_packetizer_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int PKT_LEN = DEF_PKT_LEN,
    parameter int SIZE_W  = DEF_SIZE_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    input  logic              i_flush,
    input  logic              i_tmanager_ready,
    output logic              o_tanswer_ready,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tanswer_data_last,
    output logic [SIZE_W-1:0] o_packet_size_in_bytes,
    output logic              o_busy,
    output logic              o_full,
    output logic              o_drop
);
    localparam int CW = $clog2(DEPTH) + 1;

    task_output_state_e state_q, state_d;
    logic [CW-1:0]      wcnt_q, wcnt_d, rem_q, rem_d, wcnt_post;
    logic [SIZE_W-1:0]  size_q, size_d;
    logic               wr_en, beat, trigger;
    logic [DATA_W-1:0]  fifo_rdata;
    logic               fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_count;

    sync_fifo_showahead #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_clr_n (i_rst_n),
        .i_wr    (wr_en),
        .i_wdata (i_data),
        .i_rd    (beat),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    // handshake / trigger decode
    always_comb begin
        wr_en     = (state_q == S_LOAD) && i_data_valid && !fifo_full;
        beat      = (state_q == S_SEND) && i_tmanager_ready && !fifo_empty;
        // a write in the same cycle as a flush counts toward the packet
        wcnt_post = wcnt_q + CW'(wr_en);
        trigger   = (state_q == S_LOAD) &&
                    ((wr_en && (wcnt_post == CW'(PKT_LEN))) ||
                     (i_flush && (wcnt_post != '0)));
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= S_LOAD;
        else          state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (trigger) state_d = S_START;
            S_START: state_d = S_SEND;
            S_SEND:  if (beat && (rem_q == CW'(1))) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    // outputs
    always_comb begin
        o_tanswer_ready        = (state_q == S_SEND);
        o_tanswer_data_last    = (state_q == S_SEND) && (rem_q == CW'(1));
        o_tdata                = fifo_rdata;
        o_packet_size_in_bytes = size_q;
        o_busy                 = (state_q != S_LOAD);
        o_full                 = (fifo_count == CW'(DEPTH));
        // any valid word that was not written is lost
        o_drop                 = i_data_valid && !wr_en;
    end

    // word counter, remaining beats, size register
    always_comb begin
        wcnt_d = wcnt_q;
        rem_d  = rem_q;
        size_d = size_q;
        case (state_q)
            S_LOAD: wcnt_d = wcnt_post;
            S_START: begin
                rem_d  = wcnt_q;
                size_d = SIZE_W'(words_to_bytes(32'(wcnt_q), DATA_W));
                wcnt_d = '0;
            end
            S_SEND: begin
                if (beat) begin
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) size_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wcnt_q <= '0;
            rem_q  <= '0;
            size_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            rem_q  <= rem_d;
            size_q <= size_d;
        end
    end

endmodule

// File: doc/task_output_packetizer.md
# task_output_packetizer

Parametrised output stage between a task core and the task manager. It buffers task result words in an internal FIFO and releases them as one packet. A packet is released when a programmable word count is reached, or earlier on an explicit flush. Each packet is sent over a ready/last handshake with a byte-size header, generalising the fixed-width, fixed-size, full-triggered output stage used by earlier tasks.

## Interface
Parameters:
- DATA_W, 8: word width in bits; must be a multiple of 8.
- DEPTH, 256: FIFO depth in words; power of two, at least 2.
- PKT_LEN, 256: words per full packet; 1 ≤ PKT_LEN ≤ DEPTH.
- SIZE_W, 12: width of the byte-size output; must hold PKT_LEN*DATA_W/8.

Ports:
- i_clk, in, 1: single clock; all logic is rising-edge.
- i_rst_n, in, 1: reset, synchronous, active-low. This is already decided.
- i_data, in, DATA_W: result word from the task core.
- i_data_valid, in, 1: i_data is valid this cycle.
- i_flush, in, 1: single-cycle request to send the partial packet.
- i_tmanager_ready, in, 1: the manager accepts a word this cycle.
- o_tanswer_ready, out, 1: packet word valid on o_tdata.
- o_tdata, out, DATA_W: packet word.
- o_tanswer_data_last, out, 1: the current o_tdata is the final word of the packet.
- o_packet_size_in_bytes, out, SIZE_W: byte count of the packet being sent; 0 otherwise.
- o_busy, out, 1: block is not accepting input (S_START or S_SEND).
- o_full, out, 1: FIFO holds DEPTH words.
- o_drop, out, 1: one-cycle pulse when an input word is discarded.

## Operation
- The state machine has three states: S_LOAD, S_START and S_SEND.
- S_LOAD:
  - A word is written when i_data_valid=1 and the FIFO is not full.
  - The word counter wcnt (width clog2(DEPTH)+1) increments on each write.
  - Go to S_START when either condition holds:
    - a write makes wcnt==PKT_LEN;
    - i_flush=1 and the post-write wcnt>0.
  - i_flush with wcnt==0 and no write is ignored.
- S_START (one cycle):
  - Latch rem = wcnt.
  - Latch o_packet_size_in_bytes = wcnt*(DATA_W/8), truncated to SIZE_W bits.
  - Clear wcnt.
  - Go to S_SEND.
- S_SEND:
  - o_tanswer_ready=1.
  - A beat transfers when o_tanswer_ready && i_tmanager_ready; the FIFO pops and rem decrements.
  - o_tanswer_data_last = (rem==1), held until that beat transfers.
  - After the last beat, return to S_LOAD.
  - o_tanswer_ready and o_packet_size_in_bytes drop to 0 on the following cycle.
- Drops:
  - Any i_data_valid=1 while in S_START or S_SEND is discarded and pulses o_drop.
  - A write attempt to a full FIFO in S_LOAD is also discarded and pulses o_drop.
  - A full FIFO cannot occur in S_LOAD when PKT_LEN ≤ DEPTH, but the check is kept.
- i_flush outside S_LOAD is ignored; it is not queued.
- FIFO output is show-ahead: o_tdata equals the head word whenever the FIFO is not empty.
- o_tdata is don't-care while o_tanswer_ready=0.

## Timing
- Reset values: state S_LOAD, FIFO empty, wcnt=0, rem=0. All outputs are 0 except o_tdata, which is don't-care.
- Reset mid-packet takes effect at the edge where i_rst_n=0. The in-flight packet and FIFO contents are discarded and no last is issued.
- Trigger latency, with the trigger at edge k:
  - S_START is in effect from k+1.
  - o_tanswer_ready=1 and the size is valid from k+2.
  - The first word is presented at k+2.
- Throughput is one word per cycle while i_tmanager_ready=1. Stalls hold o_tdata, o_tanswer_data_last and rem.
- PKT_LEN=1 or a 1-word flush gives a single beat with o_tanswer_data_last=1 on the first cycle.
- Simultaneous write and flush: the write is counted first and included in the packet.
- A write in the last S_LOAD cycle is kept. A write in the S_START cycle is dropped.
- All outputs are registered or decoded from registered state and counters. There are no combinational paths from i_* to o_*, except o_drop and the FIFO pop path.

## Structure
- Shared task package:
  - the state enum `task_output_state_e` {S_LOAD, S_START, S_SEND};
  - the default parameter values;
  - a function computing bytes from words.
- Sub-module `sync_fifo_showahead`, parameters DATA_W and DEPTH:
  - write, read and synchronous active-low clear;
  - full, empty and count outputs;
  - a read from empty and a write to full are ignored.
- The top level holds the FSM, wcnt, rem, size register and drop logic. The target is about 200 lines of RTL.

## Test plan
- DATA_W=8, PKT_LEN=4, manager always ready. Write 0x11..0x44 → ready rises 2 cycles after the 4th write; beats 0x11,0x22,0x33,0x44; last on 0x44; size=4; then size returns to 0.
- DATA_W=32, PKT_LEN=8. Write 3 words, then pulse i_flush → size=12; 3 beats; last on the 3rd.
- Stall: i_tmanager_ready toggles 1,0,0,1 during the send → o_tdata and last are held during the low cycles, and no word is lost or repeated.
- Drops: 2 writes during S_SEND → o_drop pulses twice. The next packet holds only post-return writes.
- Edge cases: flush with an empty FIFO → no packet. Write plus flush in the same cycle with wcnt=0 → a 1-word packet with last on its first beat.
- Reset: assert i_rst_n=0 mid-packet after 2 of 4 beats → all outputs 0 next cycle. The next 4 writes form a clean packet with none of the old data.
